// File: rtl/ucpu_host_ctrl.sv
// rtl/ucpu_host_ctrl.sv - host command controller for UltraTiny CPU program load and run gating
// One command byte in, at most one response byte out; sole memory writer while the CPU is halted.
module ucpu_host_ctrl #(
  parameter int ADDR_W       = 4,
  parameter int STEP_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              cpu_run,
  output logic              cpu_rst_n,
  input  logic              cpu_instr_done,
  input  logic [7:0]        cpu_acc,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_DATA, S_WR, S_RD, S_STEP_WAIT, S_RST_PULSE, S_RESP
  } state_t;

  localparam logic [7:0] RSP_ERR = 8'hEE;
  localparam logic [7:0] RSP_TMO = 8'hEF;
  localparam logic [3:0] TMO_MAX = 4'(STEP_TIMEOUT);

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_WRITE  = 4'h1;
  localparam logic [3:0] OP_READ   = 4'h2;
  localparam logic [3:0] OP_RUN    = 4'h3;
  localparam logic [3:0] OP_HALT   = 4'h4;
  localparam logic [3:0] OP_STEP   = 4'h5;
  localparam logic [3:0] OP_RDACC  = 4'h6;
  localparam logic [3:0] OP_CPURST = 4'h7;

  state_t              state_q, state_d;
  logic                cpu_run_q, cpu_run_d;
  logic                cpu_rst_n_q, cpu_rst_n_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic [7:0]          rsp_data_q, rsp_data_d;
  logic [3:0]          tmo_cnt_q, tmo_cnt_d;
  logic                rst_cnt_q, rst_cnt_d;
  logic                wr_ok_q, wr_ok_d;
  logic                cmd_fire;
  logic [3:0]          opcode;

  assign cmd_ready = (state_q == S_IDLE) || (state_q == S_GET_DATA);
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign opcode    = cmd_data[7:4];

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_run   = cpu_run_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign halted    = ~cpu_run_q;

  always_comb begin
    state_d     = state_q;
    cpu_run_d   = cpu_run_q;
    cpu_rst_n_d = cpu_rst_n_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_data_d  = rsp_data_q;
    tmo_cnt_d   = tmo_cnt_q;
    rst_cnt_d   = rst_cnt_q;
    wr_ok_d     = wr_ok_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          case (opcode)
            OP_NOP: ;
            OP_WRITE: begin
              // The data byte is always consumed; the halted check is frozen here.
              wr_ok_d    = ~cpu_run_q;
              mem_addr_d = cmd_data[ADDR_W-1:0];
              state_d    = S_GET_DATA;
            end
            OP_READ: begin
              if (cpu_run_q) begin
                rsp_data_d = RSP_ERR;
                state_d    = S_RESP;
              end else begin
                mem_addr_d = cmd_data[ADDR_W-1:0];
                state_d    = S_RD;
              end
            end
            OP_RUN:  cpu_run_d = 1'b1;
            OP_HALT: cpu_run_d = 1'b0;
            OP_STEP: begin
              if (cpu_run_q) begin
                rsp_data_d = RSP_ERR;
                state_d    = S_RESP;
              end else begin
                cpu_run_d = 1'b1;
                tmo_cnt_d = 4'd0;
                state_d   = S_STEP_WAIT;
              end
            end
            OP_RDACC: begin
              rsp_data_d = cpu_acc;
              state_d    = S_RESP;
            end
            OP_CPURST: begin
              cpu_run_d   = 1'b0;
              cpu_rst_n_d = 1'b0;
              rst_cnt_d   = 1'b0;
              state_d     = S_RST_PULSE;
            end
            default: begin
              rsp_data_d = RSP_ERR;
              state_d    = S_RESP;
            end
          endcase
        end
      end

      S_GET_DATA: begin
        if (cmd_fire) begin
          if (wr_ok_q) begin
            mem_wdata_d = cmd_data;
            mem_we_d    = 1'b1;
            rsp_data_d  = cmd_data;
            state_d     = S_WR;
          end else begin
            rsp_data_d = RSP_ERR;
            state_d    = S_RESP;
          end
        end
      end

      S_WR: state_d = S_RESP;

      S_RD: begin
        rsp_data_d = mem_rdata;
        state_d    = S_RESP;
      end

      S_STEP_WAIT: begin
        // Completion takes priority over a timeout landing in the same cycle.
        if (cpu_instr_done) begin
          cpu_run_d  = 1'b0;
          rsp_data_d = cpu_acc;
          state_d    = S_RESP;
        end else begin
          tmo_cnt_d = (tmo_cnt_q == 4'hF) ? tmo_cnt_q : tmo_cnt_q + 4'd1;
          if (tmo_cnt_d >= TMO_MAX) begin
            cpu_run_d  = 1'b0;
            rsp_data_d = RSP_TMO;
            state_d    = S_RESP;
          end
        end
      end

      S_RST_PULSE: begin
        if (rst_cnt_q) begin
          cpu_rst_n_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          rst_cnt_d = 1'b1;
        end
      end

      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cpu_run_q   <= 1'b0;
      cpu_rst_n_q <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      rsp_data_q  <= 8'h00;
      tmo_cnt_q   <= 4'd0;
      rst_cnt_q   <= 1'b0;
      wr_ok_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpu_run_q   <= cpu_run_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_data_q  <= rsp_data_d;
      tmo_cnt_q   <= tmo_cnt_d;
      rst_cnt_q   <= rst_cnt_d;
      wr_ok_q     <= wr_ok_d;
    end
  end

endmodule

// File: tb/tb_ucpu_host_ctrl.sv
// tb/tb_ucpu_host_ctrl.sv - self-checking bench for ucpu_host_ctrl
// Command-level model predicts responses and memory writes; directed checks pin cycle timing.
module tb_ucpu_host_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       cpu_run;
  logic       cpu_rst_n;
  logic       cpu_instr_done;
  logic [7:0] cpu_acc;
  logic       halted;

  always #5 clk = ~clk;

  ucpu_host_ctrl #(.ADDR_W(4), .STEP_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_run(cpu_run), .cpu_rst_n(cpu_rst_n), .cpu_instr_done(cpu_instr_done),
    .cpu_acc(cpu_acc), .halted(halted)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Program memory: combinational read, written by the controller's strobe.
  logic [7:0] mem_arr [16];
  assign mem_rdata = mem_arr[mem_addr];
  always @(posedge clk) if (mem_we) mem_arr[mem_addr] <= mem_wdata;

  // CPU stand-in: completes an instruction after done_at consecutive run cycles (0 = never).
  int run_cnt = 0;
  int last_run_len = 0;
  int done_at = 0;
  always @(negedge clk) begin
    if (cpu_run) run_cnt++;
    else begin
      if (run_cnt > 0) last_run_len = run_cnt;
      run_cnt = 0;
    end
    cpu_instr_done = (done_at != 0) && (run_cnt == done_at);
  end

  // Command-level reference model.
  logic [7:0]  m_mem [16];
  bit          m_run = 1'b0;
  bit          m_wr_pend = 1'b0;
  bit          m_wr_ok = 1'b0;
  logic [3:0]  m_addr = 4'd0;
  logic [7:0]  exp_rsp [$];
  logic [11:0] exp_wr [$];

  task automatic model_accept(input logic [7:0] b);
    if (m_wr_pend) begin
      m_wr_pend = 1'b0;
      if (m_wr_ok) begin
        m_mem[m_addr] = b;
        exp_wr.push_back({m_addr, b});
        exp_rsp.push_back(b);
      end else exp_rsp.push_back(8'hEE);
    end else begin
      case (b[7:4])
        4'h0: ;
        4'h1: begin m_wr_pend = 1'b1; m_wr_ok = !m_run; m_addr = b[3:0]; end
        4'h2: exp_rsp.push_back(m_run ? 8'hEE : m_mem[b[3:0]]);
        4'h3: m_run = 1'b1;
        4'h4: m_run = 1'b0;
        4'h5: exp_rsp.push_back(m_run ? 8'hEE : ((done_at != 0) ? cpu_acc : 8'hEF));
        4'h6: exp_rsp.push_back(cpu_acc);
        4'h7: m_run = 1'b0;
        default: exp_rsp.push_back(8'hEE);
      endcase
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_wr_pend = 1'b0;
    exp_rsp.delete();
    exp_wr.delete();
  endtask

  // Continuous compare against the model.
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    if (!rst_n) prev_stall = 1'b0;
    else begin
      check("halted_vs_run", {31'd0, halted}, {31'd0, ~cpu_run});
      if (mem_we) begin
        if (exp_wr.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h required no write", mem_addr, mem_wdata);
        end else check("mem_write", {20'd0, mem_addr, mem_wdata}, {20'd0, exp_wr.pop_front()});
      end
      if (prev_stall) begin
        check("rsp_hold_valid", {31'd0, rsp_valid}, 32'd1);
        check("rsp_hold_data", {24'd0, rsp_data}, {24'd0, prev_data});
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rsp: got 0x%0h required no response", rsp_data);
        end else check("rsp_data", {24'd0, rsp_data}, {24'd0, exp_rsp.pop_front()});
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = rsp_data;
    end
  end

  // Call at posedge+1; returns at posedge+1 of the cycle after the accept cycle.
  task automatic send(input logic [7:0] b);
    int n = 0;
    cmd_data  = b;
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!cmd_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL cmd_accept_timeout: got cmd_ready=0 required 1 for byte 0x%0h", b);
    end
    @(posedge clk);
    model_accept(b);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat, output logic [7:0] d);
    bit got = 1'b0;
    lat = 0;
    d = 8'h00;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (rsp_valid && rsp_ready) begin
        d = rsp_data;
        got = 1'b1;
      end
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL rsp_timeout: got no response required one within 40 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] d;
    int n;

    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_data = 8'h00;
    rsp_ready = 1'b1;
    cpu_acc = 8'h2C;
    for (int i = 0; i < 16; i++) begin
      mem_arr[i] = 8'(i * 8'h11);
      m_mem[i]   = 8'(i * 8'h11);
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {24'd0, rsp_data}, 32'h00);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {28'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    check("rst_cpu_run", {31'd0, cpu_run}, 32'd0);
    check("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    check("rst_halted", {31'd0, halted}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Halted write then read back.
    send(8'h13);
    check("wr_get_data_ready", {31'd0, cmd_ready}, 32'd1);
    send(8'h5A);
    check("wr_we_t1", {31'd0, mem_we}, 32'd1);
    check("wr_addr_t1", {28'd0, mem_addr}, 32'd3);
    check("wr_data_t1", {24'd0, mem_wdata}, 32'h5A);
    wait_rsp(lat, d);
    check("wr_rsp_lat", lat, 32'd2);
    check("wr_rsp_val", {24'd0, d}, 32'h5A);
    send(8'h23);
    wait_rsp(lat, d);
    check("rd_rsp_lat", lat, 32'd2);
    check("rd_rsp_val", {24'd0, d}, 32'h5A);

    // Running: write refused, step refused, RDACC allowed.
    send(8'h30);
    check("run_t1", {31'd0, cpu_run}, 32'd1);
    send(8'h12);
    send(8'h77);
    wait_rsp(lat, d);
    check("run_wr_rsp", {24'd0, d}, 32'hEE);
    check("run_wr_still_run", {31'd0, cpu_run}, 32'd1);
    send(8'h50);
    wait_rsp(lat, d);
    check("run_step_rsp", {24'd0, d}, 32'hEE);
    cpu_acc = 8'h91;
    send(8'h60);
    wait_rsp(lat, d);
    check("rdacc_lat", lat, 32'd1);
    check("rdacc_val", {24'd0, d}, 32'h91);
    send(8'h40);
    check("halt_t1", {31'd0, cpu_run}, 32'd0);

    // STEP with completion after 4 run cycles.
    cpu_acc = 8'h2C;
    done_at = 4;
    send(8'h50);
    check("step_run_t1", {31'd0, cpu_run}, 32'd1);
    wait_rsp(lat, d);
    check("step_lat", lat, 32'd5);
    check("step_val", {24'd0, d}, 32'h2C);
    check("step_run_len", last_run_len, 32'd4);
    check("step_halted", {31'd0, halted}, 32'd1);

    // STEP with no completion: timeout.
    done_at = 0;
    send(8'h50);
    wait_rsp(lat, d);
    check("tmo_val", {24'd0, d}, 32'hEF);
    check("tmo_run_len", last_run_len, 32'd15);
    check("tmo_cpu_run", {31'd0, cpu_run}, 32'd0);

    // Response back-pressure.
    rsp_ready = 1'b0;
    send(8'h23);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stall_rsp_seen", {31'd0, rsp_valid}, 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_data", {24'd0, rsp_data}, 32'h5A);
      check("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_rsp(lat, d);
    check("stall_release_val", {24'd0, d}, 32'h5A);
    check("stall_release_ready", {31'd0, cmd_ready}, 32'd1);

    // Unknown opcode, top address, NOP.
    send(8'hF0);
    wait_rsp(lat, d);
    check("unk_lat", lat, 32'd1);
    check("unk_val", {24'd0, d}, 32'hEE);
    send(8'h1F);
    send(8'hA5);
    wait_rsp(lat, d);
    send(8'h2F);
    wait_rsp(lat, d);
    check("addr_f_val", {24'd0, d}, 32'hA5);
    send(8'h05);
    repeat (3) @(posedge clk);
    #1;
    check("nop_no_rsp", {31'd0, rsp_valid}, 32'd0);

    // CPURST from running.
    send(8'h30);
    send(8'h70);
    check("cpurst_t1_rst", {31'd0, cpu_rst_n}, 32'd0);
    check("cpurst_t1_run", {31'd0, cpu_run}, 32'd0);
    check("cpurst_t1_ready", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("cpurst_t2_rst", {31'd0, cpu_rst_n}, 32'd0);
    @(posedge clk);
    #1;
    check("cpurst_t3_rst", {31'd0, cpu_rst_n}, 32'd1);
    check("cpurst_t3_ready", {31'd0, cmd_ready}, 32'd1);

    // Reset while waiting for a write's data byte.
    send(8'h14);
    check("gd_ready", {31'd0, cmd_ready}, 32'd1);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("midrst_we", {31'd0, mem_we}, 32'd0);
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_cpu_run", {31'd0, cpu_run}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("postrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    send(8'h24);
    wait_rsp(lat, d);
    check("postrst_mem4", {24'd0, d}, 32'h44);

    repeat (3) @(posedge clk);
    check("rsp_queue_drained", exp_rsp.size(), 32'd0);
    check("wr_queue_drained", exp_wr.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
